// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 16-bit registered ALU between two requesters.
//
// A request from port 0 (fetch/decode) or port 1 (auxiliary) is accepted on a
// valid/ready handshake and latched. The ALU is driven for exactly one cycle,
// and the result is returned on a single response channel. The response carries
// cleaned flags and the id of the requester. Undefined opcodes (11-15) are
// answered with rsp_err_o and never reach the ALU. Outside the execute cycle
// the ALU sees opcode 15, so its result register holds.
//
// Optional feature macro: ALU_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration with a 1-bit preference pointer
//   undefined -> fixed priority, requester 0 wins ties
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid_i / req_ready_o      per-requester request handshake (bit i = requester i)
//   reqN_codop_i, reqN_op1_i,
//   reqN_op2_i, reqN_imm_i         request opcode and operands
//   rsp_valid_o / rsp_ready_i      response handshake
//   rsp_id_o, rsp_result_o,
//   rsp_neg_o, rsp_zero_o,
//   rsp_overflow_o, rsp_err_o      response payload
//   alu_codop_o, alu_op*_o         ALU inputs
//   alu_result_i, alu_neg_i,
//   alu_overflow_i                 ALU outputs; the ALU zero flag is not used
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [3:0]  req0_codop_i,
  input  logic [15:0] req0_op1_i,
  input  logic [15:0] req0_op2_i,
  input  logic [15:0] req0_imm_i,
  input  logic [3:0]  req1_codop_i,
  input  logic [15:0] req1_op1_i,
  input  logic [15:0] req1_op2_i,
  input  logic [15:0] req1_imm_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [15:0] rsp_result_o,
  output logic        rsp_neg_o,
  output logic        rsp_zero_o,
  output logic        rsp_overflow_o,
  output logic        rsp_err_o,
  output logic [3:0]  alu_codop_o,
  output logic [15:0] alu_op1_o,
  output logic [15:0] alu_op2_o,
  output logic [15:0] alu_imm_o,
  input  logic [15:0] alu_result_i,
  input  logic        alu_neg_i,
  input  logic        alu_overflow_i
);

  typedef enum logic [1:0] {StIdle, StExec, StDone, StErr} state_e;

  localparam logic [3:0] CodopNop    = 4'd15;
  localparam logic [3:0] CodopMaxDef = 4'd10;

  state_e      state_q;
  logic [3:0]  codop_q;
  logic [15:0] op1_q, op2_q, imm_q;
  logic        id_q;

  logic [1:0]  gnt;
  logic        sel_id;
  logic [3:0]  sel_codop;
  logic [15:0] sel_op1, sel_op2, sel_imm;
  logic        flags_en;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic ptr_q;

  // The pointer only breaks ties; a lone requester is always granted.
  always_comb begin
    gnt = req_valid_i;
    if (req_valid_i == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
  end
`else
  assign gnt = {req_valid_i[1] & ~req_valid_i[0], req_valid_i[0]};
`endif

  // Ready is forced low while reset is held, even though the state already reads idle.
  assign req_ready_o = ((state_q == StIdle) && rst_n) ? gnt : 2'b00;

  assign sel_id    = gnt[1];
  assign sel_codop = sel_id ? req1_codop_i : req0_codop_i;
  assign sel_op1   = sel_id ? req1_op1_i   : req0_op1_i;
  assign sel_op2   = sel_id ? req1_op2_i   : req0_op2_i;
  assign sel_imm   = sel_id ? req1_imm_i   : req0_imm_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      codop_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      imm_q   <= '0;
      id_q    <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|gnt) begin
            codop_q <= sel_codop;
            op1_q   <= sel_op1;
            op2_q   <= sel_op2;
            imm_q   <= sel_imm;
            id_q    <= sel_id;
            state_q <= (sel_codop <= CodopMaxDef) ? StExec : StErr;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            ptr_q   <= ~sel_id;
`endif
          end
        end
        StExec: state_q <= StDone;
        StDone: if (rsp_ready_i) state_q <= StIdle;
        StErr:  if (rsp_ready_i) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Only add/sub style opcodes produce meaningful N/V flags from the ALU.
  assign flags_en = codop_q inside {4'd0, 4'd1, 4'd9, 4'd10};

  always_comb begin
    alu_codop_o    = CodopNop;
    alu_op1_o      = '0;
    alu_op2_o      = '0;
    alu_imm_o      = '0;
    rsp_valid_o    = 1'b0;
    rsp_id_o       = 1'b0;
    rsp_result_o   = '0;
    rsp_neg_o      = 1'b0;
    rsp_zero_o     = 1'b0;
    rsp_overflow_o = 1'b0;
    rsp_err_o      = 1'b0;
    unique case (state_q)
      StExec: begin
        alu_codop_o = codop_q;
        alu_op1_o   = op1_q;
        alu_op2_o   = op2_q;
        alu_imm_o   = imm_q;
      end
      // The ALU sees opcode 15 here, so alu_result_i is stable for the whole response.
      StDone: begin
        rsp_valid_o    = 1'b1;
        rsp_id_o       = id_q;
        rsp_result_o   = alu_result_i;
        rsp_neg_o      = alu_neg_i & flags_en;
        rsp_overflow_o = alu_overflow_i & flags_en;
        rsp_zero_o     = (alu_result_i == 16'h0000);
      end
      StErr: begin
        rsp_valid_o = 1'b1;
        rsp_id_o    = id_q;
        rsp_err_o   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
